// File: rtl/elastic_register_pkg.sv
// Shared limits and width helper for the elastic register pipeline.
package elastic_register_pkg;

    localparam int NUM_STAGES_MAX = 16;
    localparam int DATA_WIDTH_MAX = 1024;

    // Occupancy counter width; a zero-stage pipeline still exposes a 1-bit port.
    function automatic int occ_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One valid/data stage of the elastic pipeline with its ready equation.
module elastic_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int RESET_DATA = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  clr,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  ready,
    input  logic                  next_ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] dout
);

    logic take;

    assign ready = !valid || next_ready;
    assign take  = up_valid && ready;

    always_ff @(posedge CLK) begin
        if (RESET || clr)
            valid <= 1'b0;
        else if (take)
            valid <= 1'b1;
        else if (next_ready)
            valid <= 1'b0;
    end

    // A clear drops only the valid bit; the word itself stays where it is.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (RESET_DATA != 0)
                dout <= '0;
        end else if (!clr && take) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/elastic_register.sv
// Elastic valid/ready pipeline of NUM_STAGES bubble-collapsing stages.
// Optional FLUSH input enabled by defining ELASTIC_REGISTER_FLUSH_EN.
module elastic_register
    import elastic_register_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int DATA_WIDTH = 8,
    parameter int RESET_DATA = 1
) (
    input  logic                             CLK,
    input  logic                             RESET,
`ifdef ELASTIC_REGISTER_FLUSH_EN
    input  logic                             FLUSH,
`endif
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [DATA_WIDTH-1:0]            DIN,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [DATA_WIDTH-1:0]            DOUT,
    output logic [occ_w(NUM_STAGES)-1:0]     OCCUPANCY
);

    localparam int OCC_W = occ_w(NUM_STAGES);

    logic flush;
`ifdef ELASTIC_REGISTER_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    generate
        if (NUM_STAGES == 0) begin : g_wire
            assign DOUT      = DIN;
            assign OUT_VALID = IN_VALID;
            assign IN_READY  = OUT_READY;
            assign OCCUPANCY = '0;
        end else begin : g_pipe
            logic [NUM_STAGES:0]                 vld_pipe;
            logic [NUM_STAGES:0]                 rdy;
            logic [NUM_STAGES:0][DATA_WIDTH-1:0] dat;
            logic [OCC_W-1:0]                    occ_cnt;
            logic                                gate;

            // Nothing enters while reset or flush owns the pipeline.
            assign gate            = !RESET && !flush;
            assign vld_pipe[0]     = IN_VALID && gate;
            assign dat[0]          = DIN;
            assign rdy[NUM_STAGES] = OUT_READY;

            for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
                elastic_stage #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .RESET_DATA (RESET_DATA)
                ) u_stage (
                    .CLK        (CLK),
                    .RESET      (RESET),
                    .clr        (flush),
                    .up_valid   (vld_pipe[i]),
                    .din        (dat[i]),
                    .ready      (rdy[i]),
                    .next_ready (rdy[i+1]),
                    .valid      (vld_pipe[i+1]),
                    .dout       (dat[i+1])
                );
            end

            always_comb begin
                occ_cnt = '0;
                for (int i = 1; i <= NUM_STAGES; i++)
                    occ_cnt = occ_cnt + OCC_W'(vld_pipe[i]);
            end

            assign IN_READY  = rdy[0] && gate;
            assign OUT_VALID = vld_pipe[NUM_STAGES];
            assign DOUT      = dat[NUM_STAGES];
            assign OCCUPANCY = occ_cnt;
        end
    endgenerate

endmodule

// File: doc/elastic_register.md
ELASTIC_REGISTER -- requirements
Module: elastic_register

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2: pipeline depth; legal range 0..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: payload width; legal range 1..1024.
REQ-003 SHALL have parameter RESET_DATA, default 1: 1 = data registers clear on reset; 0 = only valid bits clear.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port IN_VALID  input  1  upstream presents DIN.
REQ-007 SHALL have port IN_READY  output  1  block accepts DIN this cycle.
REQ-008 SHALL have port DIN  input  DATA_WIDTH  upstream payload.
REQ-009 SHALL have port OUT_VALID  output  1  DOUT holds a valid word.
REQ-010 SHALL have port OUT_READY  input  1  downstream accepts DOUT.
REQ-011 SHALL have port DOUT  output  DATA_WIDTH  payload at the last stage.
REQ-012 SHALL have port OCCUPANCY  output  OCC_W  number of valid stages; OCC_W = clog2(NUM_STAGES+1), minimum 1.

Function
REQ-013 Stage i (0..NUM_STAGES-1) SHALL hold one valid bit and one DATA_WIDTH data word; stage 0 is fed by DIN, and the last stage drives DOUT/OUT_VALID.
REQ-014 Stage readiness SHALL be ready_i = !valid_i OR ready_(i+1); ready of the last stage = !valid_last OR OUT_READY; IN_READY = ready_0.
REQ-015 A transfer into stage i SHALL occur when its upstream valid and ready_i are both 1; data then latches and valid_i sets.
REQ-016 Stage i SHALL clear valid_i when it hands off downstream without receiving a new word in the same cycle.
REQ-017 Stage i SHALL hold data and valid unchanged when valid_i=1 and ready_(i+1)=0.
REQ-018 Bubbles SHALL collapse: an empty stage accepts from upstream even while downstream stalls.
REQ-019 Latency SHALL be exactly NUM_STAGES cycles from an IN_VALID&IN_READY transfer to OUT_VALID when no stall occurs.
REQ-020 Sustained throughput SHALL be one word per cycle while OUT_READY=1.
REQ-021 Word order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-022 With NUM_STAGES=0, the block SHALL be purely combinational: DOUT=DIN, OUT_VALID=IN_VALID, IN_READY=OUT_READY, OCCUPANCY=0.
REQ-023 Full condition: with all stages valid and OUT_READY=0, IN_READY SHALL be 0; when OUT_READY rises, IN_READY SHALL be 1 in the same cycle (combinational ready path).
REQ-024 Simultaneous accept and emit when full SHALL keep OCCUPANCY unchanged.
REQ-025 OCCUPANCY SHALL equal the registered popcount of the valid bits, updated each cycle.
REQ-026 DOUT SHALL be unspecified (but stable) when OUT_VALID=0.

Reset
REQ-027 When RESET=1 at a rising edge, all valid bits SHALL clear; OUT_VALID=0 and OCCUPANCY=0 from the next cycle.
REQ-028 When RESET_DATA=1, all data registers and DOUT SHALL reset to 0; when RESET_DATA=0, data SHALL be left unreset.
REQ-029 IN_READY SHALL be 0 while RESET=1; a transfer presented during reset SHALL be discarded.
REQ-030 A reset asserted mid-stream SHALL discard all in-flight words, with no partial output.

Configuration
REQ-031 Macro ELASTIC_REGISTER_FLUSH_EN SHALL, when defined, add input FLUSH (1 bit, synchronous, active-high).
REQ-032 With the macro defined, FLUSH=1 SHALL clear all valid bits at the edge, force IN_READY=0 in that cycle, leave data untouched, and yield to RESET.
REQ-033 With the macro undefined, no FLUSH port SHALL exist and behaviour SHALL be identical to FLUSH tied 0.

Structure
REQ-034 Package elastic_register_pkg SHALL hold the function computing OCC_W and the NUM_STAGES/DATA_WIDTH limit constants.
REQ-035 One sub-module, elastic_stage, SHALL implement a single valid/data stage with its ready equation; the top SHALL chain NUM_STAGES instances in a generate loop.

Verification
REQ-036 NUM_STAGES=3, DATA_WIDTH=8: stream 0x01..0x0A with OUT_READY=1 -> 0x01 appears 3 cycles after its transfer, then one word per cycle in order.
REQ-037 NUM_STAGES=3: fill with 0xA1,0xA2,0xA3 with OUT_READY=0 -> OCCUPANCY=3, IN_READY=0; raise OUT_READY -> 0xA1 accepted downstream and IN_READY=1 in the same cycle.
REQ-038 Bubble: send one word, stall output 4 cycles, send a second word -> the second word advances to stage 1 while the first is held; OCCUPANCY=2.
REQ-039 RESET pulse with OCCUPANCY=2 -> next cycle OUT_VALID=0, OCCUPANCY=0, DOUT=0 (RESET_DATA=1); no stale word emitted later.
REQ-040 NUM_STAGES=0: DIN=0x5A, IN_VALID=1, OUT_READY=0 -> DOUT=0x5A, OUT_VALID=1, IN_READY=0 in the same cycle.
REQ-041 ELASTIC_REGISTER_FLUSH_EN defined: FLUSH with 3 valid words and IN_VALID=1 -> OCCUPANCY=0 next cycle; the input word is not accepted.
